// File: rtl/tiny_cpu_seq.sv
// Instruction sequencer for the tiny CPU: fetches opcode/operand bytes over a
// request/ready byte port, sequences the shared adder and holds PC, acc, Z/C and the output port.
module tiny_cpu_seq #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    output logic [7:0] mem_addr,
    output logic       mem_req,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [8:0] alu_y,
    output logic [7:0] out_port,
    output logic       out_strobe,
    output logic       halted
);

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_OPND  = 3'd1,
        ST_DATA  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_LDM  = 4'h3;
    localparam logic [3:0] OP_ADDM = 4'h4;
    localparam logic [3:0] OP_OUT  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_JZ   = 4'h7;
    localparam logic [3:0] OP_JC   = 4'h8;
    localparam logic [3:0] OP_HLT  = 4'hF;

    function automatic logic is_two_byte(input logic [3:0] op);
        case (op)
            OP_LDM, OP_ADDM, OP_JMP, OP_JZ, OP_JC: is_two_byte = 1'b1;
            default:                               is_two_byte = 1'b0;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] opr_q, opr_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] out_q, out_d;
    logic       z_q, z_d;
    logic       c_q, c_d;
    logic       strobe_q, strobe_d;
    logic       hs_s;
    logic [3:0] op_s;
    logic [3:0] imm_s;

    assign op_s       = ir_q[7:4];
    assign imm_s      = ir_q[3:0];
    assign hs_s       = mem_req & mem_ready;
    assign alu_a      = acc_q;
    assign out_port   = out_q;
    // A strobe pending across a stall is held and only shown once ena returns.
    assign out_strobe = strobe_q & ena;
    assign halted     = (state_q == ST_HALT);

    // Memory port and adder operand B selection
    always_comb begin
        mem_req  = 1'b0;
        mem_addr = pc_q;
        alu_b    = 8'h00;
        case (state_q)
            ST_FETCH: mem_req = ena;
            ST_OPND:  mem_req = ena;
            ST_DATA: begin
                mem_req  = ena;
                mem_addr = opr_q;
                alu_b    = mem_rdata;
            end
            ST_EXEC:  alu_b = {4'h0, imm_s};
            default:  mem_req = 1'b0;
        endcase
    end

    // Next-state and architectural state update
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        opr_d    = opr_q;
        acc_d    = acc_q;
        out_d    = out_q;
        z_d      = z_q;
        c_d      = c_q;
        strobe_d = strobe_q;
        if (ena) begin
            strobe_d = 1'b0;
            case (state_q)
                ST_FETCH: begin
                    if (hs_s) begin
                        ir_d    = mem_rdata;
                        pc_d    = pc_q + 8'd1;
                        state_d = is_two_byte(mem_rdata[7:4]) ? ST_OPND : ST_EXEC;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_OPND: begin
                    if (hs_s) begin
                        opr_d   = mem_rdata;
                        pc_d    = pc_q + 8'd1;
                        state_d = ST_FETCH;
                        case (op_s)
                            OP_LDM, OP_ADDM: state_d = ST_DATA;
                            OP_JMP:          pc_d = mem_rdata;
                            OP_JZ:           pc_d = z_q ? mem_rdata : pc_q + 8'd1;
                            OP_JC:           pc_d = c_q ? mem_rdata : pc_q + 8'd1;
                            default:         state_d = ST_FETCH;
                        endcase
                    end else begin
                        state_d = ST_OPND;
                    end
                end
                ST_DATA: begin
                    if (hs_s) begin
                        state_d = ST_FETCH;
                        if (op_s == OP_LDM) begin
                            acc_d = mem_rdata;
                            z_d   = (mem_rdata == 8'h00);
                        end else begin
                            acc_d = alu_y[7:0];
                            z_d   = (alu_y[7:0] == 8'h00);
                            c_d   = alu_y[8];
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_EXEC: begin
                    state_d = ST_FETCH;
                    case (op_s)
                        OP_LDI: begin
                            acc_d = {4'h0, imm_s};
                            z_d   = (imm_s == 4'h0);
                        end
                        OP_ADDI: begin
                            acc_d = alu_y[7:0];
                            z_d   = (alu_y[7:0] == 8'h00);
                            c_d   = alu_y[8];
                        end
                        OP_OUT: begin
                            out_d    = acc_q;
                            strobe_d = 1'b1;
                        end
                        OP_HLT:  state_d = ST_HALT;
                        default: state_d = ST_FETCH;
                    endcase
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_FETCH;
            endcase
        end else begin
            strobe_d = strobe_q;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= 8'h00;
            opr_q    <= 8'h00;
            acc_q    <= 8'h00;
            out_q    <= 8'h00;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            opr_q    <= opr_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
            z_q      <= z_d;
            c_q      <= c_d;
            strobe_q <= strobe_d;
        end
    end

endmodule

// File: tb/tb_tiny_cpu_seq.sv
// Scoreboard bench for tiny_cpu_seq: an ISA-level model predicts bus addresses and
// OUT values; a negedge monitor compares them against the DUT's handshakes and strobes.
module tb_tiny_cpu_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       mem_ready = 1'b0;
    logic [7:0] mem_addr, mem_rdata, alu_a, alu_b, out_port;
    logic       mem_req, out_strobe, halted;
    logic [8:0] alu_y;
    logic [7:0] mem [0:255];

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_addr_q[$];
    logic [7:0] exp_out_q[$];
    bit         sb_on = 1'b0;
    bit         strict = 1'b0;
    int         ready_mode = 0;
    int         wait_n = 0;
    bit         ena_rand = 1'b0;
    bit         ena_force = 1'b1;

    tiny_cpu_seq #(.RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .out_port(out_port), .out_strobe(out_strobe), .halted(halted)
    );

    assign mem_rdata = mem[mem_addr];
    assign alu_y     = {1'b0, alu_a} + {1'b0, alu_b};

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ISA-level reference: walks the program and records every byte address read and every OUT value.
    task automatic model_run(input int max_instr, output bit halts);
        logic [7:0] pc, acc, a, ins;
        bit z, c;
        int s;
        pc = 8'h00; acc = 8'h00; z = 1'b0; c = 1'b0; halts = 1'b0; a = 8'h00;
        for (int n = 0; n < max_instr && !halts; n++) begin
            ins = mem[pc];
            exp_addr_q.push_back(pc);
            pc = pc + 8'd1;
            if (ins[7:4] inside {4'h3, 4'h4, 4'h6, 4'h7, 4'h8}) begin
                a = mem[pc];
                exp_addr_q.push_back(pc);
                pc = pc + 8'd1;
            end
            case (ins[7:4])
                4'h1: begin acc = {4'h0, ins[3:0]}; z = (acc == 8'h00); end
                4'h2: begin
                    s = int'(acc) + int'(ins[3:0]);
                    acc = 8'(s % 256); c = (s > 255); z = (acc == 8'h00);
                end
                4'h3: begin exp_addr_q.push_back(a); acc = mem[a]; z = (acc == 8'h00); end
                4'h4: begin
                    exp_addr_q.push_back(a);
                    s = int'(acc) + int'(mem[a]);
                    acc = 8'(s % 256); c = (s > 255); z = (acc == 8'h00);
                end
                4'h5: exp_out_q.push_back(acc);
                4'h6: pc = a;
                4'h7: if (z) pc = a;
                4'h8: if (c) pc = a;
                4'hF: halts = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        sb_on = 1'b1;
        #1 rst_n = 1'b1;
    endtask

    task automatic start_prog(input int max_instr);
        bit h;
        sb_on = 1'b0;
        exp_addr_q.delete();
        exp_out_q.delete();
        model_run(max_instr, h);
        strict = h;
        do_reset();
    endtask

    task automatic wait_drain(input string tag);
        int k;
        for (k = 0; k < 4000 && (exp_addr_q.size() > 0 || exp_out_q.size() > 0); k++)
            @(negedge clk);
        check({tag, "_drain_left"}, exp_addr_q.size() + exp_out_q.size(), 0);
        if (strict) begin
            repeat (4) @(negedge clk);
            check({tag, "_halted"}, halted, 1);
            check({tag, "_req_in_halt"}, mem_req, 0);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic load_prog1();
        clear_mem();
        mem[0] = 8'h15; mem[1] = 8'h23; mem[2] = 8'h50; mem[3] = 8'hF0;
    endtask

    task automatic run_timed(input string tag, input int rmode, input int wn, input int exp_strobe,
                             input int exp_halt, input int exp_out, input int exp_pc);
        int strobe_cyc, halt_cyc, nstrobe;
        ready_mode = rmode; wait_n = wn; ena_rand = 1'b0; ena_force = 1'b1;
        start_prog(60);
        strobe_cyc = -1; halt_cyc = -1; nstrobe = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (out_strobe) begin nstrobe++; strobe_cyc = k; end
            if (halted && halt_cyc < 0) halt_cyc = k;
        end
        check({tag, "_strobe_cycle"}, strobe_cyc, exp_strobe);
        check({tag, "_strobe_count"}, nstrobe, 1);
        check({tag, "_halt_cycle"}, halt_cyc, exp_halt);
        check({tag, "_out_port"}, out_port, exp_out);
        check({tag, "_final_pc"}, mem_addr, exp_pc);
        check({tag, "_req_after_halt"}, mem_req, 0);
    endtask

    // Input driver: ena and mem_ready change shortly after each rising edge.
    initial begin : drv
        int wcnt;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #2 ena = ena_rand ? ($urandom_range(0, 4) != 0) : ena_force;
            #1;
            if (!rst_n) begin
                wcnt = 0;
                mem_ready = (ready_mode == 0);
            end else if (ready_mode == 0) begin
                mem_ready = 1'b1;
            end else if (ready_mode == 1) begin
                if (mem_req) begin
                    if (wcnt < wait_n) begin mem_ready = 1'b0; wcnt++; end
                    else begin mem_ready = 1'b1; wcnt = 0; end
                end else begin
                    mem_ready = 1'b0;
                end
            end else begin
                mem_ready = ($urandom_range(0, 2) != 0);
            end
        end
    end

    // Monitor: pops expectations on each observed handshake and output strobe.
    initial begin : mon
        bit         prev_wait;
        logic [7:0] prev_addr;
        prev_wait = 1'b0; prev_addr = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && sb_on) begin
                if (!ena) check("stall_quiet", {mem_req, out_strobe}, 0);
                if (prev_wait && mem_req) check("addr_stable", mem_addr, prev_addr);
                if (mem_req && mem_ready) begin
                    if (exp_addr_q.size() > 0) check("bus_addr", mem_addr, exp_addr_q.pop_front());
                    else if (strict) begin
                        checks++; failures++;
                        $display("FAIL extra_req: got request at 0x%0h, expected none", mem_addr);
                    end
                end
                if (out_strobe) begin
                    if (exp_out_q.size() > 0) check("out_value", out_port, exp_out_q.pop_front());
                    else if (strict) begin
                        checks++; failures++;
                        $display("FAIL extra_strobe: got strobe with 0x%0h, expected none", out_port);
                    end
                end
            end
            prev_wait = rst_n && mem_req && !mem_ready;
            prev_addr = mem_addr;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        bit found;
        // Reset values
        clear_mem();
        #1;
        check("rst_out_port", out_port, 0);
        check("rst_strobe", out_strobe, 0);
        check("rst_halted", halted, 0);
        check("rst_acc", alu_a, 0);
        check("rst_addr", mem_addr, 8'h00);

        // Basic program with zero-wait and 3-wait memory
        load_prog1();
        run_timed("p1_zero_wait", 0, 0, 6, 8, 8'h08, 8'h04);
        run_timed("p1_wait3", 1, 3, 15, 20, 8'h08, 8'h04);

        // Carry out of ADDM gives acc=0, Z=1, C=1; JZ and JC both taken
        clear_mem();
        mem[8'h00] = 8'h1F; mem[8'h01] = 8'h40; mem[8'h02] = 8'h10;
        mem[8'h03] = 8'h70; mem[8'h04] = 8'h20; mem[8'h10] = 8'hF1;
        mem[8'h20] = 8'h50; mem[8'h21] = 8'h80; mem[8'h22] = 8'h30; mem[8'h23] = 8'hF0;
        mem[8'h30] = 8'hF0;
        ready_mode = 0; ena_rand = 1'b0; ena_force = 1'b1;
        start_prog(60);
        wait_drain("carry_z");
        check("carry_z_out", out_port, 8'h00);
        check("carry_z_pc", mem_addr, 8'h31);

        // JC not taken at 0x05
        clear_mem();
        mem[8'h00] = 8'h13; mem[8'h05] = 8'h80; mem[8'h06] = 8'h30;
        mem[8'h07] = 8'h53; mem[8'h08] = 8'h50; mem[8'h09] = 8'hF0;
        mem[8'h30] = 8'hF0;
        ready_mode = 2;
        start_prog(60);
        wait_drain("jc_not_taken");
        check("jc_not_taken_out", out_port, 8'h03);

        // ena dropped for 4 cycles while a LDM data read is pending
        clear_mem();
        mem[8'h00] = 8'h31; mem[8'h01] = 8'h40; mem[8'h02] = 8'h50; mem[8'h03] = 8'hF0;
        mem[8'h40] = 8'h9A;
        ready_mode = 1; wait_n = 6;
        start_prog(60);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            found = mem_req && !mem_ready && (mem_addr == 8'h40);
        end
        check("ena_found_data", found, 1);
        ena_force = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("ena_low_req", mem_req, 0);
            check("ena_low_addr", mem_addr, 8'h40);
            check("ena_low_acc", alu_a, 8'h00);
        end
        ena_force = 1'b1;
        wait_drain("ena_stall");
        check("ena_stall_out", out_port, 8'h9A);

        // Reset asserted during the DATA read of an ADDM
        clear_mem();
        mem[8'h00] = 8'h15; mem[8'h01] = 8'h50; mem[8'h02] = 8'h41; mem[8'h03] = 8'h40;
        mem[8'h04] = 8'h50; mem[8'h05] = 8'hF0; mem[8'h40] = 8'h22;
        ready_mode = 1; wait_n = 3;
        start_prog(60);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            found = mem_req && !mem_ready && (mem_addr == 8'h40);
        end
        check("mid_rst_found_data", found, 1);
        check("mid_rst_pre_out", out_port, 8'h05);
        sb_on = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_port", out_port, 8'h00);
        check("mid_rst_strobe", out_strobe, 0);
        check("mid_rst_halted", halted, 0);
        check("mid_rst_addr", mem_addr, 8'h00);
        check("mid_rst_acc", alu_a, 8'h00);
        start_prog(60);
        @(negedge clk);
        check("post_rst_first_req", {mem_req, mem_addr}, {1'b1, 8'h00});
        wait_drain("mid_rst");
        check("mid_rst_final_out", out_port, 8'h27);

        // PC wrap: JMP 0xFF, opcode at 0xFF fetches its operand from 0x00
        clear_mem();
        mem[8'h00] = 8'h40; mem[8'h01] = 8'h80; mem[8'h02] = 8'h60; mem[8'h03] = 8'hFF;
        mem[8'hFF] = 8'h60; mem[8'h80] = 8'h07; mem[8'h40] = 8'h50; mem[8'h41] = 8'hF0;
        ready_mode = 2;
        start_prog(60);
        wait_drain("wrap");
        check("wrap_out", out_port, 8'h07);

        // Randomized programs, random wait states and random ena stalls
        for (int t = 0; t < 24; t++) begin
            int p;
            logic [3:0] op;
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
            p = 0;
            while (p < 64) begin
                op = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 9) == 0) op = 4'hF;
                mem[p] = {op, 4'($urandom_range(0, 15))};
                if (op inside {4'h6, 4'h7, 4'h8}) begin
                    mem[p + 1] = 8'($urandom_range(0, 63));
                    p = p + 2;
                end else if (op inside {4'h3, 4'h4}) begin
                    mem[p + 1] = 8'($urandom_range(0, 255));
                    p = p + 2;
                end else begin
                    p = p + 1;
                end
            end
            ready_mode = 2;
            ena_rand = (t % 2 == 1);
            start_prog(80);
            wait_drain("rand");
        end
        ena_rand = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tiny_cpu_seq.md
# tiny_cpu_seq

Instruction sequencer for the tiny CPU. Fetches 8-bit instructions and operands over a byte-wide request/ready memory port. Drives the operands of the shared 8-bit adder datapath and holds the architectural state: PC, accumulator, Z/C flags and the output port. Sits between the top-level pins (memory bus) and the adder, and is the only block that sequences the adder.

## Interface
- RESET_PC, 8'h00, PC value loaded on reset

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  global enable; low = full stall
- mem_addr  out  8  memory byte address
- mem_req  out  1  memory read request
- mem_rdata  in  8  read data, valid when mem_ready=1
- mem_ready  in  1  completes the transfer in the same cycle
- alu_a  out  8  adder operand A
- alu_b  out  8  adder operand B
- alu_y  in  9  adder result {carry, sum}, combinational from alu_a/alu_b
- out_port  out  8  registered output port
- out_strobe  out  1  one-cycle pulse when out_port is written
- halted  out  1  high in HALT state

## Operation
- Instruction byte format: opcode = [7:4], imm = [3:0].
  - 0x0 NOP.
  - 0x1 LDI: acc←{0,imm}, updates Z.
  - 0x2 ADDI: acc←acc+{0,imm}, updates Z and C.
  - 0x3 LDM a: acc←mem[a], updates Z.
  - 0x4 ADDM a: acc←acc+mem[a], updates Z and C.
  - 0x5 OUT: out_port←acc, pulses out_strobe.
  - 0x6 JMP a.
  - 0x7 JZ a: jump if Z.
  - 0x8 JC a: jump if C.
  - 0xF HLT.
  - 0x9–0xE execute as NOP.
- Opcodes 0x3, 0x4, 0x6, 0x7 and 0x8 are two-byte: the operand byte `a` follows the opcode byte.
- Loads leave C unchanged. Z is set when the new acc == 0. C = alu_y[8].
- All adds go through alu_a/alu_b/alu_y. alu_a = acc always.
- alu_b = {4'b0, imm} in EXEC; mem_rdata in DATA; 0 otherwise.
- FSM states: FETCH, OPND, DATA, EXEC, HALT.
  - FETCH: req at PC. On handshake: ir←rdata, PC←PC+1. Go to OPND if two-byte, else EXEC.
  - OPND: req at PC. On handshake: opr←rdata, PC←PC+1.
    - LDM/ADDM: go to DATA.
    - Jumps: PC←rdata if taken, else keep PC+1; go to FETCH.
  - DATA: req at opr. On handshake: acc←rdata (LDM) or alu_y[7:0] (ADDM), update flags; go to FETCH.
  - EXEC: one cycle, performs the 1-byte op; go to FETCH, or to HALT for 0xF.
  - HALT: no requests. Exit only by reset.
- A handshake is any rising edge with ena & mem_req & mem_ready.
- mem_req = ena & (state ∈ {FETCH, OPND, DATA}), combinational.
- mem_addr = opr in DATA, PC otherwise.
- PC is 8-bit and wraps 0xFF→0x00, including the operand fetch of an instruction at 0xFF.
- ena low: no register or state changes, mem_req=0, out_strobe=0. Resumes in the same state with the same address.

## Timing
- Reset (async) values: PC=RESET_PC, acc=0, Z=0, C=0, out_port=0, out_strobe=0, state=FETCH, halted=0, ir=opr=0.
- First request after reset: mem_req=1, mem_addr=RESET_PC in the first cycle with rst_n high and ena high.
- With zero-wait memory (ready tied high):
  - 1-byte ops: 2 cycles.
  - Jumps: 2 cycles.
  - LDM/ADDM: 3 cycles.
- Each wait cycle (mem_ready=0) adds one cycle. mem_addr is stable while mem_req=1 and ready is low.
- Reset asserted mid-transfer aborts it immediately. The partial transfer has no effect.
- out_strobe is high for exactly the cycle after the OUT EXEC edge; out_port updates on the same edge.
- Flags and acc are visible the cycle after the completing edge. A JZ/JC immediately following sees the updated flags.

## Test plan
- Program 0x15,0x23,0x50,0xF0 at 0x00, zero-wait memory → out_port=0x08. out_strobe high for 1 cycle 6 cycles after reset release. halted=1 at cycle 8, PC=0x04, no further mem_req.
- Carry/Z: 0x1F, 0x40,0x10, 0x70,0x20 with mem[0x10]=0xF1 → acc=0x00, Z=1, C=1. JZ taken, next fetch address 0x20.
- Not taken: JC with C=0 at 0x05 (operand 0x30) → next fetch address 0x07; acc and flags unchanged.
- Wait states: mem_ready low for 3 cycles on every request of the first program → mem_addr stable while waiting, same final out_port=0x08, total 20 cycles.
- ena dropped for 4 cycles in DATA → mem_req=0 and all state frozen. Completes correctly after ena returns.
- Reset asserted in DATA of an ADDM → all outputs take their reset values immediately. Next mem_addr=RESET_PC. Wrap case: JMP 0xFF with mem[0xFF]=0x60, mem[0x00]=0x40 → fetch addresses 0xFF, 0x00, 0x40.
